// File: rtl/ring_sched_pkg.sv
// Shared types and constants for the ring scheduler: FSM state encoding,
// colour and job-type constants, and the hold-timer width helper.
package ring_sched_pkg;

    typedef enum logic [2:0] {
        S_CLEAR_INIT = 3'd0,
        S_IDLE       = 3'd1,
        S_GRANT      = 3'd2,
        S_CALC       = 3'd3,
        S_DRAW       = 3'd4,
        S_WAIT       = 3'd5,
        S_HOLD       = 3'd6
    } state_t;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic       JOB_VIS      = 1'b0;
    localparam logic       JOB_ERASE    = 1'b1;

    // A hold of a single cycle still needs a one-bit counter.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/ring_scheduler_if.sv
// Request/grant and datapath-control bundle between the scheduler (slave)
// and its requesters plus line plotter (master).
interface ring_scheduler_if #(
    parameter int NUM_LINES = 16
);
    localparam int LW = $clog2(NUM_LINES);

    logic          vis_req;
    logic [2:0]    vis_colour;
    logic          erase_req;
    logic          busy;
    logic          vis_gnt;
    logic          erase_gnt;
    logic          calc;
    logic          draw;
    logic [LW-1:0] line_number;
    logic [2:0]    colour_out;
    logic          ring_on_screen;
    logic          frame_done;
    logic [2:0]    state;

    modport master (
        output vis_req, vis_colour, erase_req, busy,
        input  vis_gnt, erase_gnt, calc, draw, line_number, colour_out,
               ring_on_screen, frame_done, state
    );

    modport slave (
        input  vis_req, vis_colour, erase_req, busy,
        output vis_gnt, erase_gnt, calc, draw, line_number, colour_out,
               ring_on_screen, frame_done, state
    );

endinterface

// File: rtl/hold_timer.sv
// Loadable down-counter that measures how long a drawn ring stays visible;
// it parks at zero and reports expiry there.
module hold_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    // Count register: load wins over decrement, never wraps below zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/ring_scheduler.sv
// Arbitrates visualizer/eraser ring jobs and sequences the line calculator
// and plotter through NUM_LINES calc/draw pairs, then holds drawn rings.
module ring_scheduler
    import ring_sched_pkg::*;
#(
    parameter int NUM_LINES   = 16,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    ring_scheduler_if.slave  bus
);

    localparam int LW = $clog2(NUM_LINES);
    localparam int TW = timer_width(HOLD_CYCLES);
    localparam logic [LW-1:0] LAST_LINE = LW'(NUM_LINES - 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

    state_t        r_state;
    logic          r_job;
    logic          r_wait_first;
    logic [LW-1:0] r_line;
    logic [2:0]    r_colour;
    logic          r_ring_on_screen;
    logic          r_vis_gnt;
    logic          r_erase_gnt;
    logic          r_calc;
    logic          r_draw;
    logic          r_frame_done;

    logic w_wait_done;
    logic w_timer_load;
    logic w_timer_en;
    logic w_expired;

    // WAIT ignores busy on its first cycle because the plotter only raises it then.
    assign w_wait_done  = (r_state == S_WAIT) && !r_wait_first && !bus.busy;
    assign w_timer_load = w_wait_done && (r_line == LAST_LINE) && (r_job == JOB_VIS);
    assign w_timer_en   = (r_state == S_HOLD);

    hold_timer #(.W(TW)) u_hold_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_timer_load),
        .i_load_val (HOLD_LOAD),
        .i_en       (w_timer_en),
        .o_expired  (w_expired)
    );

    // Scheduler FSM; every output pulse is registered on entry to its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_CLEAR_INIT;
            r_job            <= JOB_ERASE;
            r_wait_first     <= 1'b0;
            r_line           <= '0;
            r_colour         <= COLOUR_BLACK;
            r_ring_on_screen <= 1'b0;
            r_vis_gnt        <= 1'b0;
            r_erase_gnt      <= 1'b0;
            r_calc           <= 1'b0;
            r_draw           <= 1'b0;
            r_frame_done     <= 1'b0;
        end else begin
            r_vis_gnt    <= 1'b0;
            r_erase_gnt  <= 1'b0;
            r_calc       <= 1'b0;
            r_draw       <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_CLEAR_INIT: begin
                    r_job    <= JOB_ERASE;
                    r_colour <= COLOUR_BLACK;
                    r_line   <= '0;
                    r_calc   <= 1'b1;
                    r_state  <= S_CALC;
                end
                S_IDLE: begin
                    if (r_ring_on_screen && bus.erase_req) begin
                        r_job       <= JOB_ERASE;
                        r_erase_gnt <= 1'b1;
                        r_state     <= S_GRANT;
                    end else if (bus.vis_req) begin
                        r_job     <= JOB_VIS;
                        r_vis_gnt <= 1'b1;
                        r_state   <= S_GRANT;
                    end else if (bus.erase_req) begin
                        r_job       <= JOB_ERASE;
                        r_erase_gnt <= 1'b1;
                        r_state     <= S_GRANT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    r_colour <= (r_job == JOB_VIS) ? bus.vis_colour : COLOUR_BLACK;
                    r_line   <= '0;
                    r_calc   <= 1'b1;
                    r_state  <= S_CALC;
                end
                S_CALC: begin
                    r_draw  <= 1'b1;
                    r_state <= S_DRAW;
                end
                S_DRAW: begin
                    r_wait_first <= 1'b1;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    r_wait_first <= 1'b0;
                    if (!w_wait_done) begin
                        r_state <= S_WAIT;
                    end else if (r_line != LAST_LINE) begin
                        r_line  <= r_line + LW'(1);
                        r_calc  <= 1'b1;
                        r_state <= S_CALC;
                    end else if (r_job == JOB_VIS) begin
                        r_ring_on_screen <= 1'b1;
                        r_state          <= S_HOLD;
                    end else begin
                        r_ring_on_screen <= 1'b0;
                        r_frame_done     <= 1'b1;
                        r_state          <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (w_expired) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_state <= S_HOLD;
                    end
                end
                default: begin
                    r_state <= S_CLEAR_INIT;
                end
            endcase
        end
    end

    assign bus.vis_gnt        = r_vis_gnt;
    assign bus.erase_gnt      = r_erase_gnt;
    assign bus.calc           = r_calc;
    assign bus.draw           = r_draw;
    assign bus.line_number    = r_line;
    assign bus.colour_out     = r_colour;
    assign bus.ring_on_screen = r_ring_on_screen;
    assign bus.frame_done     = r_frame_done;
    assign bus.state          = r_state;

endmodule
